clmul_seq_gf2: RTL

Sequential digit-serial carry-less (GF(2)[x]) multiplier producing the pointwise products consumed by the Toom-K interpolation stages, including the exact-division-by-(x^4+x^2) stage. Operands enter through a valid/ready handshake. Each cycle retires D bits of `b`. The 2W-bit product is presented on a valid/ready output port and held until accepted. With W=32 the output width 2W=64 matches the N=64 division stage directly.

---
 rtl/clmul_seq_gf2.sv | 126 ++++++++++++
 1 files changed

// File: rtl/clmul_seq_gf2.sv
// clmul_seq_gf2: digit-serial carry-less (GF(2)[x]) multiplier.
//
// Retires D bits of the multiplier per cycle; a W x W operand pair yields a
// 2W-bit product after W/D RUN cycles. The product is held on p with
// out_valid high until the consumer accepts it.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand pair valid
//   in_ready   block can accept an operand pair (IDLE and not in reset)
//   a          multiplicand, bit i = coefficient of x^i
//   b          multiplier, bit i = coefficient of x^i
//   out_valid  p holds a finished product
//   out_ready  consumer accepts p
//   p          product a*b over GF(2); bit 2W-1 is always 0
module clmul_seq_gf2 #(
  parameter int unsigned W = 32,
  parameter int unsigned D = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p
);

  localparam int unsigned Steps = W / D;
  localparam int unsigned CntW  = $clog2(Steps + 1);

  if (W % D != 0) begin : g_digit_check
    $error("clmul_seq_gf2: W must be a multiple of D");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [2*W-1:0]    a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [2*W-1:0]    acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]    partial;
  logic              last_digit;

  assign last_digit = (cnt_q == CntW'(Steps - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)   state_d = StRun;
      StRun:   if (last_digit) state_d = StDone;
      StDone:  if (out_ready)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode from state only; in_ready is additionally masked by reset.
  always_comb begin
    in_ready  = (state_q == StIdle) && !rst;
    out_valid = (state_q == StDone);
  end

  assign p = acc_q;

  // XOR of the current digit's shifted multiplicand copies.
  always_comb begin
    partial = '0;
    for (int unsigned j = 0; j < D; j++) begin
      if (b_q[j]) partial = partial ^ (a_q << j);
    end
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d   = {{W{1'b0}}, a};
          b_d   = b;
          acc_d = '0;
          cnt_d = '0;
        end
      end
      StRun: begin
        // A is 2W wide, so nothing useful is shifted out before the last digit.
        acc_d = acc_q ^ partial;
        a_d   = a_q << D;
        b_d   = b_q >> D;
        cnt_d = cnt_q + CntW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
